// File: rtl/usart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the arbiter and the USART
// transmitter. The master side is the environment (requesters plus the
// transmitter's done pulse); the slave side is the arbiter itself.
interface usart_tx_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_BIT = 8,
  parameter int ID_W     = 3
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*DATA_BIT-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ack;
  logic [DATA_BIT-1:0]         tx_data;
  logic                        tx_toggle;
  logic                        tx_done;
  logic                        busy;
  logic [ID_W-1:0]             grant_id;
  logic                        timeout_err;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ack, tx_data, tx_toggle, busy, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ack, tx_data, tx_toggle, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART transmitter among NUM_REQ requesters.
// A grant loads the winner's byte, acks it for one cycle and flips tx_toggle;
// the arbiter then waits for tx_done, or gives up after TIMEOUT_CLKS cycles.
module usart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BIT     = 8,
  parameter int TIMEOUT_CLKS = 12000,
  parameter int ID_W         = 3
) (
  input  logic                clk,
  input  logic                reset,
  usart_tx_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    cnt;

  logic                hi_found;
  logic                lo_found;
  logic [ID_W-1:0]     hi_w;
  logic [ID_W-1:0]     lo_w;
  logic [DATA_BIT-1:0] hi_d;
  logic [DATA_BIT-1:0] lo_d;
  logic [ID_W-1:0]     winner;
  logic [DATA_BIT-1:0] win_data;
  logic [ID_W-1:0]     next_ptr;

  // Winner search: first pending requester at or above rr_ptr, else the
  // first one below it, which is the wrap-around part of the rotation.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_w     = '0;
    lo_w     = '0;
    hi_d     = '0;
    lo_d     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        if (i >= int'(rr_ptr)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_w     = ID_W'(i);
            hi_d     = bus.req_data[i*DATA_BIT +: DATA_BIT];
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_w     = ID_W'(i);
          lo_d     = bus.req_data[i*DATA_BIT +: DATA_BIT];
        end
      end
    end
    winner   = hi_found ? hi_w : lo_w;
    win_data = hi_found ? hi_d : lo_d;
  end

  // Pointer advance past the requester just served, wrapping at NUM_REQ-1.
  always_comb begin
    next_ptr = (bus.grant_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.grant_id + 1'b1;
  end

  // Grant/wait FSM with all outputs registered; ack and timeout are pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      cnt             <= '0;
      bus.req_ack     <= '0;
      bus.tx_data     <= '0;
      bus.tx_toggle   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.grant_id    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.req_ack     <= '0;
      bus.timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            bus.tx_data   <= win_data;
            bus.grant_id  <= winner;
            bus.req_ack   <= NUM_REQ'(1) << winner;
            bus.tx_toggle <= ~bus.tx_toggle;
            bus.busy      <= 1'b1;
            cnt           <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // tx_done takes priority over a coincident watchdog expiry.
          if (bus.tx_done) begin
            rr_ptr   <= next_ptr;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
            bus.timeout_err <= 1'b1;
            rr_ptr          <= next_ptr;
            bus.busy        <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed bench for usart_tx_arbiter: a vector table for single-cycle
// behaviour plus hand-written round-robin, timeout and coincidence sequences.
module tb_usart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int IW = 3;
  localparam int TO = 50;

  logic clk;
  logic reset;

  usart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BIT(DB), .ID_W(IW)) bus ();

  usart_tx_arbiter #(.NUM_REQ(NR), .DATA_BIT(DB), .TIMEOUT_CLKS(TO), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        done;
    logic [3:0]  ack;
    logic [7:0]  txd;
    logic        tog;
    logic        busy;
    logic [2:0]  gid;
    logic        terr;
    logic [2:0]  ptr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic rst, logic [3:0] valid, logic [31:0] data, logic done,
                              logic [3:0] ack, logic [7:0] txd, logic tog, logic busy,
                              logic [2:0] gid, logic terr, logic [2:0] ptr);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.done = done;
    v.ack = ack; v.txd = txd; v.tog = tog; v.busy = busy;
    v.gid = gid; v.terr = terr; v.ptr = ptr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.tx_done = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int first_to;
    int to_pulses;
    int acks_seen;
    logic [7:0] exp_d [5];

    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;

    //               rst valid   data           done ack     txd    tog busy gid terr ptr
    vecs[0]  = mk(1, 4'b0000, 32'h443322A5, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 4'b0001, 32'h443322A5, 0, 4'b0001, 8'hA5, 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 4'b0000, 32'h443322A5, 0, 4'b0000, 8'hA5, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 4'b0000, 32'h443322A5, 1, 4'b0000, 8'hA5, 1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 4'b0000, 32'h44332211, 0, 4'b0000, 8'hA5, 1, 0, 0, 0, 1);
    vecs[5]  = mk(0, 4'b0000, 32'h44332211, 1, 4'b0000, 8'hA5, 1, 0, 0, 0, 1);
    vecs[6]  = mk(0, 4'b1011, 32'h44332211, 0, 4'b0010, 8'h22, 0, 1, 1, 0, 1);
    vecs[7]  = mk(0, 4'b1001, 32'h44332211, 1, 4'b0000, 8'h22, 0, 0, 1, 0, 2);
    vecs[8]  = mk(0, 4'b1011, 32'h44332211, 0, 4'b1000, 8'h44, 1, 1, 3, 0, 2);
    vecs[9]  = mk(0, 4'b0011, 32'h44332211, 1, 4'b0000, 8'h44, 1, 0, 3, 0, 0);
    vecs[10] = mk(0, 4'b0011, 32'h44332211, 0, 4'b0001, 8'h11, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 4'b0010, 32'h44332211, 0, 4'b0000, 8'h11, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, 4'b0010, 32'h44332211, 1, 4'b0000, 8'h11, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 4'b0010, 32'h44332211, 0, 4'b0010, 8'h22, 1, 1, 1, 0, 1);
    vecs[14] = mk(1, 4'b0000, 32'h44332211, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 4'b0100, 32'h44332211, 0, 4'b0100, 8'h33, 1, 1, 2, 0, 0);
    vecs[16] = mk(0, 4'b0000, 32'h44332211, 1, 4'b0000, 8'h33, 1, 0, 2, 0, 3);

    for (int i = 0; i < 17; i++) begin
      reset = vecs[i].rst;
      bus.req_valid = vecs[i].valid;
      bus.req_data = vecs[i].data;
      bus.tx_done = vecs[i].done;
      step();
      check($sformatf("v%0d.ack", i),  32'(bus.req_ack),     32'(vecs[i].ack));
      check($sformatf("v%0d.txd", i),  32'(bus.tx_data),     32'(vecs[i].txd));
      check($sformatf("v%0d.tog", i),  32'(bus.tx_toggle),   32'(vecs[i].tog));
      check($sformatf("v%0d.busy", i), 32'(bus.busy),        32'(vecs[i].busy));
      check($sformatf("v%0d.gid", i),  32'(bus.grant_id),    32'(vecs[i].gid));
      check($sformatf("v%0d.terr", i), 32'(bus.timeout_err), 32'(vecs[i].terr));
      check($sformatf("v%0d.ptr", i),  32'(dut.rr_ptr),      32'(vecs[i].ptr));
    end

    // Round robin with all four requesters continuously pending.
    do_reset();
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44; exp_d[4] = 8'h11;
    bus.req_data = 32'h44332211;
    bus.req_valid = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d.gid", k),  32'(bus.grant_id),  32'(k % NR));
      check($sformatf("rr%0d.txd", k),  32'(bus.tx_data),   32'(exp_d[k]));
      check($sformatf("rr%0d.ack", k),  32'(bus.req_ack),   32'(1 << (k % NR)));
      check($sformatf("rr%0d.tog", k),  32'(bus.tx_toggle), 32'((k + 1) % 2));
      check($sformatf("rr%0d.busy", k), 32'(bus.busy),      32'd1);
      repeat (19) step();
      check($sformatf("rr%0d.hold", k), 32'(bus.tx_data),   32'(exp_d[k]));
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      check($sformatf("rr%0d.gap", k),  32'(bus.busy),      32'd0);
      if (k < 4) step();
    end
    bus.req_valid = '0;

    // Watchdog: requester 2 granted, tx_done never arrives.
    do_reset();
    bus.req_valid = 4'b0100;
    step();
    check("to.gid", 32'(bus.grant_id), 32'd2);
    check("to.tog", 32'(bus.tx_toggle), 32'd1);
    bus.req_valid = '0;
    first_to = -1;
    to_pulses = 0;
    acks_seen = 0;
    for (int j = 1; j <= 60; j++) begin
      step();
      if (bus.req_ack != '0) acks_seen++;
      if (bus.timeout_err) begin
        to_pulses++;
        if (first_to < 0) first_to = j;
      end
      if (j == TO) begin
        check("to.busy", 32'(bus.busy), 32'd0);
        check("to.tog_kept", 32'(bus.tx_toggle), 32'd1);
        check("to.ptr", 32'(dut.rr_ptr), 32'd3);
      end
    end
    check("to.cycle", 32'(first_to), 32'(TO));
    check("to.pulses", 32'(to_pulses), 32'd1);
    check("to.no_ack", 32'(acks_seen), 32'd0);

    // tx_done on the same edge as the watchdog terminal count.
    do_reset();
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    repeat (TO - 1) step();
    check("co.busy_before", 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("co.terr", 32'(bus.timeout_err), 32'd0);
    check("co.busy", 32'(bus.busy), 32'd0);
    check("co.ptr", 32'(dut.rr_ptr), 32'd1);
    step();
    check("co.terr_after", 32'(bus.timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
